// File: rtl/decoder_str.sv
// decoder_str: registered 2-to-4 one-hot decoder with enable.
// Outputs and valid update one cycle after the sampling edge.
module decoder_str (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic I1,
    input  logic I0,
    output logic D3,
    output logic D2,
    output logic D1,
    output logic D0,
    output logic valid
);

    logic [1:0] sel;
    logic [3:0] dec_d;
    logic [3:0] dec_q;
    logic       valid_d;
    logic       valid_q;

    assign sel = {I1, I0};

    // Next-state decode: one-hot on sel when enabled, all low otherwise.
    always_comb begin
        dec_d   = 4'b0000;
        valid_d = 1'b0;
        if (en) begin
            valid_d = 1'b1;
            unique case (1'b1)
                (sel == 2'b00): dec_d = 4'b0001;
                (sel == 2'b01): dec_d = 4'b0010;
                (sel == 2'b10): dec_d = 4'b0100;
                (sel == 2'b11): dec_d = 4'b1000;
                default:        dec_d = 4'b0000;
            endcase
        end
    end

    // Output registers; reset wins over any decode sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    assign D3    = dec_q[3];
    assign D2    = dec_q[2];
    assign D1    = dec_q[1];
    assign D0    = dec_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_str.sv
// tb_decoder_str: directed scoreboard bench for decoder_str.
// Expected outputs are queued at drive time and popped after each edge.
module tb_decoder_str;

    logic clk;
    logic rst;
    logic en;
    logic I1;
    logic I0;
    logic D3;
    logic D2;
    logic D1;
    logic D0;
    logic valid;

    int vectors;
    int miscompares;

    logic [4:0] sb_q[$];
    logic [4:0] last_exp;

    decoder_str dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .I1    (I1),
        .I0    (I0),
        .D3    (D3),
        .D2    (D2),
        .D1    (D1),
        .D0    (D0),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] model(input logic r, input logic e,
                                         input logic [1:0] c);
        logic [3:0] d;
        if (r || !e) return 5'b00000;
        d = 4'b0001 << c;
        return {d, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        logic [3:0] d;
        obs = {D3, D2, D1, D0, valid};
        d   = {D3, D2, D1, D0};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: D3..D0,valid=%b expected %b", tag, obs, exp);
        end
        vectors++;
        assert (($countones(d) <= 1) && (valid === (|d))) else begin
            miscompares++;
            $error("FAIL %s_inv: D3..D0=%b valid=%b expected onehot0, valid=OR",
                   tag, d, valid);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e,
                        input logic [1:0] c);
        @(negedge clk);
        rst = r;
        en  = e;
        {I1, I0} = c;
        sb_q.push_back(model(r, e, c));
        @(posedge clk);
        #1;
        last_exp = sb_q.pop_front();
        check(tag, last_exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b1;
        I1  = 1'b1;
        I0  = 1'b1;

        step("reset0", 1'b1, 1'b1, 2'b11);
        step("reset1", 1'b1, 1'b1, 2'b11);

        step("dec00", 1'b0, 1'b1, 2'b00);
        step("dec01", 1'b0, 1'b1, 2'b01);
        step("dec10", 1'b0, 1'b1, 2'b10);
        step("dec11", 1'b0, 1'b1, 2'b11);

        for (int i = 0; i < 4; i++) begin
            step("dis", 1'b0, 1'b0, 2'(i));
        end

        for (int i = 0; i < 4; i++) begin
            step("hold10", 1'b0, 1'b1, 2'b10);
            #2 I0 = 1'b1;
            #1 check("glitch", last_exp);
        end

        step("str11", 1'b0, 1'b1, 2'b11);
        step("str00", 1'b0, 1'b1, 2'b00);
        step("midrst", 1'b1, 1'b1, 2'b01);
        step("resume", 1'b0, 1'b1, 2'b01);
        step("str10", 1'b0, 1'b1, 2'b10);

        for (int i = 0; i < 16; i++) begin
            step("rand", 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)));
        end

        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_empty: size=%0d expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_str.md
DECODER_STR -- requirements
Module: decoder_str

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled on rising clk.
REQ-004 en  input  1  decode enable; 1 = decode the select inputs, 0 = force all decode outputs low.
REQ-005 I1  input  1  select bit 1 (MSB of the 2-bit code).
REQ-006 I0  input  1  select bit 0 (LSB of the 2-bit code).
REQ-007 D3  output  1  decode output for code 2'b11; registered.
REQ-008 D2  output  1  decode output for code 2'b10; registered.
REQ-009 D1  output  1  decode output for code 2'b01; registered.
REQ-010 D0  output  1  decode output for code 2'b00; registered.
REQ-011 valid  output  1  high in a cycle whose D3..D0 reflect an enabled decode; registered.

Function
REQ-012 The block SHALL implement a 2-to-4 one-hot decoder of code {I1,I0} with output Dk = 1 when {I1,I0} == k and en = 1.
REQ-013 D3..D0 and valid SHALL be registered: inputs sampled on rising clk edge N appear on the outputs after edge N, giving a latency of exactly 1 cycle.
REQ-014 With en = 1 at the sampling edge, exactly one of D3..D0 SHALL be 1 and the other three SHALL be 0, and valid SHALL be 1.
REQ-015 With en = 0 at the sampling edge, D3..D0 SHALL all be 0 and valid SHALL be 0, regardless of I1/I0.
REQ-016 Mapping: {I1,I0} = 00 -> D0; 01 -> D1; 10 -> D2; 11 -> D3.
REQ-017 Outputs SHALL change only on rising clk edges; input changes between edges SHALL have no effect on the outputs until the next edge.
REQ-018 A new code SHALL be accepted on every cycle with no handshake; back-to-back code changes SHALL each produce the corresponding one-hot output one cycle later.
REQ-019 Outputs SHALL never show more than one Dk high in any cycle.
REQ-020 The block SHALL contain no state other than the five output registers.

Reset
REQ-021 When rst = 1 at a rising clk edge, D3..D0 SHALL be 0 and valid SHALL be 0 after that edge, regardless of en, I1 and I0.
REQ-022 rst SHALL take priority over en and the select inputs.
REQ-023 Outputs SHALL stay 0 for every edge at which rst is held high.
REQ-024 After rst is deasserted, the first edge with en = 1 SHALL produce a valid decode one cycle later, with no extra warm-up cycles.
REQ-025 Asserting rst mid-stream SHALL clear the outputs on that edge, discarding the code sampled on that edge.

Verification
REQ-026 rst=1 for 2 cycles with en=1, {I1,I0}=11 -> D3..D0=0000 and valid=0 throughout.
REQ-027 rst=0, en=1, apply {I1,I0}=00, 01, 10, 11 on consecutive cycles -> one cycle later D3..D0 = 0001, 0010, 0100, 1000 respectively, with valid=1 each cycle.
REQ-028 en=0 with each of the four codes -> D3..D0=0000 and valid=0 one cycle later.
REQ-029 Toggle I0 between clock edges while holding {I1,I0}=10 at each edge -> outputs remain 0100 with no glitch at the edges.
REQ-030 Stream codes with en=1, then assert rst for 1 cycle in the middle -> the output after that edge is 0000 with valid=0, and decoding resumes correctly on the next cycle.
REQ-031 Every cycle of every test -> at most one of D3..D0 is high, and valid == (D3|D2|D1|D0).
